// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the multiply/divide sequencing controller
package muldiv_pkg;
    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULH = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;
    localparam logic [1:0] OP_REM  = 2'b11;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/muldiv_watchdog.sv
// muldiv_watchdog: bounds a unit operation to TIMEOUT busy cycles
// Ports: clk, rst_n (async active-low), clear (zero the count),
//        enable (count this cycle), expired (last allowed cycle reached).
module muldiv_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable)
            cnt <= cnt + 1'b1;
    end

    assign expired = enable && (cnt == W'(TIMEOUT - 1));
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences one MUL/MULH/DIV/REM through the shared multi-cycle unit
// Ports: req_* (execute-stage request, req_ready high in IDLE), flush (abort),
//        stall (pipeline hold), rsp_* (one-cycle result strobe, rsp_err = timeout),
//        md_* (unit handshake: md_rst_n, md_valid, md_mode, md_a, md_b, md_ready, md_out).
// Option: define MULDIV_DIVZERO_FAST_EN to answer DIV/REM by zero without the unit.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        req_ready,
    input  logic        flush,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        md_rst_n,
    output logic        md_valid,
    output logic        md_mode,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    input  logic        md_ready,
    input  logic [63:0] md_out
);
    state_t      state, state_d;
    logic        sel_hi;
    logic        accept, expired, fast_dz;
    logic [31:0] data_d;
    logic        err_d;

    assign accept    = (state == ST_IDLE) && req_valid && !flush;
    assign req_ready = (state == ST_IDLE);
    assign stall     = ((state == ST_IDLE) && req_valid) || (state == ST_ISSUE) || (state == ST_BUSY);

`ifdef MULDIV_DIVZERO_FAST_EN
    assign fast_dz = ((req_op == OP_DIV) || (req_op == OP_REM)) && (req_b == '0);
`else
    assign fast_dz = 1'b0;
`endif

    muldiv_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state == ST_ISSUE),
        .enable  (state == ST_BUSY),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        data_d  = rsp_data;
        err_d   = rsp_err;
        case (state)
            ST_IDLE: begin
                if (accept)
                    state_d = fast_dz ? ST_DONE : ST_ISSUE;
                if (accept && fast_dz) begin
                    data_d = (req_op == OP_REM) ? req_a : '1;
                    err_d  = 1'b0;
                end
            end
            ST_ISSUE: state_d = ST_BUSY;
            ST_BUSY: begin
                if (md_ready || expired)
                    state_d = ST_DONE;
                // a ready result always beats an expiring watchdog in the same cycle
                data_d = md_ready ? (sel_hi ? md_out[63:32] : md_out[31:0]) : expired ? '0 : rsp_data;
                err_d  = md_ready ? 1'b0 : expired ? 1'b1 : rsp_err;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush && state != ST_IDLE)
            state_d = ST_IDLE;
    end

    // the handshake outputs are registered from the next state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_valid  <= 1'b0;
            md_rst_n  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            md_mode   <= MODE_MUL;
            md_a      <= '0;
            md_b      <= '0;
            sel_hi    <= 1'b0;
        end else begin
            md_valid  <= (state_d == ST_ISSUE);
            md_rst_n  <= (state_d == ST_ISSUE) || (state_d == ST_BUSY);
            rsp_valid <= (state_d == ST_DONE);
            rsp_data  <= data_d;
            rsp_err   <= err_d;
            if (accept) begin
                md_mode <= req_op[1] ? MODE_DIV : MODE_MUL;
                md_a    <= req_a;
                md_b    <= req_b;
                // MULH and REM both take the upper half of the unit result
                sel_hi  <= req_op[0];
            end
        end
    end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: self-checking bench for muldiv_ctrl with a behavioural unit model
module tb_muldiv_ctrl;
    localparam int TO = 8;
`ifdef MULDIV_DIVZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    localparam logic [1:0] MUL = 2'b00, MULH = 2'b01, DIV = 2'b10, REM = 2'b11;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, flush = 1'b0;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_a = '0, req_b = '0;
    logic        req_ready, stall, rsp_valid, rsp_err, md_rst_n, md_valid, md_mode;
    logic [31:0] rsp_data, md_a, md_b;
    logic        md_ready = 1'b0;
    logic [63:0] md_out;

    int n_cmp = 0, n_fail = 0;

    muldiv_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .flush(flush),
        .stall(stall), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .md_rst_n(md_rst_n), .md_valid(md_valid), .md_mode(md_mode),
        .md_a(md_a), .md_b(md_b), .md_ready(md_ready), .md_out(md_out)
    );

    always #5 clk = ~clk;

    // unit model: raises ready unit_lat cycles after its start, never when unit_lat < 0
    int          unit_lat = 0;
    int          ucnt = -1;
    logic [31:0] ua = '0, ub = '0;
    logic        umode = 1'b0;

    always @(posedge clk) begin
        if (!md_rst_n) begin
            md_ready <= 1'b0;
            ucnt     <= -1;
        end else if (md_valid) begin
            ua       <= md_a;
            ub       <= md_b;
            umode    <= md_mode;
            md_ready <= (unit_lat == 0);
            ucnt     <= (unit_lat > 0) ? unit_lat - 1 : -1;
        end else if (ucnt >= 0) begin
            md_ready <= (ucnt == 0);
            ucnt     <= ucnt - 1;
        end
    end

    assign md_out = umode ? {(ub == 0) ? ua : ua % ub, (ub == 0) ? 32'hFFFF_FFFF : ua / ub}
                          : {32'b0, ua} * {32'b0, ub};

    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'b0, a} * {32'b0, b};
        case (op)
            MUL:     return p[31:0];
            MULH:    return p[63:32];
            DIV:     return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [31:0] exp_d, input logic exp_e, input int exp_l);
        int   cyc = 0, nv = 0;
        logic got = 1'b0, stall_bad = 1'b0;
        unit_lat = lat;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        #1 check("stall_accept", stall, 1);
        while (!got && cyc < 40) begin
            @(negedge clk);
            req_valid = 1'b0;
            cyc++;
            if (md_valid) begin
                nv++;
                check("md_mode", md_mode, op[1]);
                check("md_ab", {md_a, md_b}, {a, b});
            end
            if (rsp_valid) begin
                got = 1'b1;
                check("rsp_data", rsp_data, exp_d);
                check("rsp_err", rsp_err, exp_e);
                check("latency", cyc, exp_l);
                check("md_rst_n_done", md_rst_n, 0);
                check("stall_done", stall, 0);
            end else if (!stall) begin
                stall_bad = 1'b1;
            end
        end
        check("rsp_seen", got, 1);
        check("md_valid_pulses", nv, (exp_l == 1) ? 0 : 1);
        check("stall_held", stall_bad, 0);
        @(negedge clk);
        check("rsp_one_cycle", rsp_valid, 0);
        check("req_ready_after", req_ready, 1);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b;
        int          lat;
        logic [31:0] d;
        logic        e;
        int          l;
    } vec_t;
    vec_t vecs[7];

    initial begin
        int cyc;
        vecs[0] = '{MUL,  32'd7,          32'd6,   4,  32'd42,         1'b0, 7};
        vecs[1] = '{MULH, 32'h8000_0000, 32'd4,   1,  32'd2,          1'b0, 4};
        vecs[2] = '{REM,  32'd23,         32'd6,   0,  32'd5,          1'b0, 3};
        vecs[3] = '{DIV,  32'd100,        32'd7,   2,  32'd14,         1'b0, 5};
        vecs[4] = '{MUL,  32'd5,          32'd9,   -1, 32'd0,          1'b1, 2 + TO};
        vecs[5] = '{MUL,  32'd3,          32'd3,   TO - 1, 32'd9,      1'b0, 2 + TO};
        vecs[6] = '{DIV,  32'd100,        32'd0,   1,  32'hFFFF_FFFF, 1'b0, FAST ? 1 : 4};

        #12;
        check("rst_req_ready", req_ready, 1);
        check("rst_md_rst_n", md_rst_n, 0);
        check("rst_flags", {stall, rsp_valid, rsp_err, md_valid, md_mode}, 0);
        check("rst_data", {rsp_data, md_a}, 0);
        check("rst_md_b", md_b, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].d, vecs[i].e, vecs[i].l);

        // flush while idle blocks the accept
        @(negedge clk);
        req_valid = 1'b1; req_op = MUL; flush = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        check("idle_flush_ready", req_ready, 1);
        check("idle_flush_md_valid", md_valid, 0);
        check("idle_flush_md_rst_n", md_rst_n, 0);

        // flush coinciding with md_ready wins
        unit_lat = 2;
        @(negedge clk);
        req_valid = 1'b1; req_op = MUL; req_a = 32'd5; req_b = 32'd5;
        cyc = 0;
        do begin
            @(negedge clk);
            req_valid = 1'b0;
            cyc++;
        end while (!md_ready && cyc < 20);
        check("flush_ready_seen", md_ready, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_rsp_valid", rsp_valid, 0);
        check("flush_req_ready", req_ready, 1);
        check("flush_md_rst_n", md_rst_n, 0);
        @(negedge clk);
        check("flush_rsp_valid2", rsp_valid, 0);

        // asynchronous reset in the middle of BUSY
        unit_lat = -1;
        @(negedge clk);
        req_valid = 1'b1; req_op = DIV; req_a = 32'd50; req_b = 32'd7;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_state", {stall, md_rst_n, md_mode}, 3'b111);
        rst_n = 1'b0;
        #1;
        check("arst_req_ready", req_ready, 1);
        check("arst_flags", {stall, rsp_valid, rsp_err, md_valid, md_mode, md_rst_n}, 0);
        check("arst_data", {rsp_data, md_a}, 0);
        check("arst_md_b", md_b, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(MUL, 32'd3, 32'd3, 0, 32'd9, 1'b0, 3);

        // randomized traffic against the arithmetic reference
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  op;
            logic [31:0] a, b, d;
            int          lat, l;
            logic        e;
            op  = 2'($urandom_range(0, 3));
            a   = $urandom;
            b   = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            lat = $urandom_range(0, TO + 1);
            if (lat >= TO) lat = -1;
            if (FAST && op[1] && b == 0) begin
                d = ref_res(op, a, b); e = 1'b0; l = 1;
            end else if (lat < 0) begin
                d = 32'd0; e = 1'b1; l = 2 + TO;
            end else begin
                d = ref_res(op, a, b); e = 1'b0; l = 3 + lat;
            end
            run_op(op, a, b, lat, d, e, l);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
